// File: rtl/mul_unit_if.sv
// Request/response bundle between a pipeline issuing multiply ops and mul_unit.
// valid/ready: a request is taken on a rising edge where valid=1 and ready=1;
// done pulses for one cycle with result, and no backpressure exists on the response.
interface mul_unit_if;
    logic        valid;
    logic [2:0]  funct3;
    logic        is_word;
    logic [63:0] srca;
    logic [63:0] srcb;
    logic        flush;
    logic        ready;
    logic        done;
    logic [63:0] result;

    modport master (
        output valid, funct3, is_word, srca, srcb, flush,
        input  ready, done, result
    );

    modport slave (
        input  valid, funct3, is_word, srca, srcb, flush,
        output ready, done, result
    );
endinterface

// File: rtl/mul_unit.sv
// RISC-V MUL/MULH/MULHSU/MULHU/MULW sequencer around an external unsigned 64x64 multiplier.
// Signed forms multiply magnitudes and negate the 128-bit product afterwards.
module mul_unit (
    input  logic         clk,
    input  logic         reset,
    mul_unit_if.slave    req,
    output logic         mul_valid,
    output logic [63:0]  mul_a,
    output logic [63:0]  mul_b,
    input  logic         mul_done,
    input  logic [127:0] mul_c,
    output logic [2:0]   fsm_state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        FIX   = 3'd3,
        RESP  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_MULW   = 3'd4
    } op_t;

    state_t       state, state_next;
    op_t          op_reg, op_dec;
    logic         neg_reg, neg_dec;
    logic [63:0]  a_reg, b_reg, mag_a, mag_b;
    logic [127:0] prod_reg, prod_fix;
    logic [63:0]  result_reg, result_fix;
    logic         accept;

    // Two's-complement magnitude; 0x8000..0 maps to itself, which is correct unsigned.
    function automatic logic [63:0] abs64(input logic [63:0] x);
        return x[63] ? (~x + 64'd1) : x;
    endfunction

    always_comb begin
        op_dec = OP_MUL;
        if (req.is_word) begin
            op_dec = OP_MULW;
        end else begin
            case (req.funct3)
                3'b001:  op_dec = OP_MULH;
                3'b010:  op_dec = OP_MULHSU;
                3'b011:  op_dec = OP_MULHU;
                default: op_dec = OP_MUL;
            endcase
        end
    end

    always_comb begin
        mag_a   = req.srca;
        mag_b   = req.srcb;
        neg_dec = 1'b0;
        case (op_dec)
            OP_MULH: begin
                mag_a   = abs64(req.srca);
                mag_b   = abs64(req.srcb);
                neg_dec = req.srca[63] ^ req.srcb[63];
            end
            OP_MULHSU: begin
                mag_a   = abs64(req.srca);
                neg_dec = req.srca[63];
            end
            OP_MULW: begin
                mag_a = {32'd0, req.srca[31:0]};
                mag_b = {32'd0, req.srcb[31:0]};
            end
            default: ;
        endcase
    end

    assign accept = (state == IDLE) && req.valid && !req.flush;

    always_comb begin
        state_next = state;
        if (req.flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (req.valid) state_next = ISSUE;
                ISSUE:   state_next = WAIT;
                WAIT:    if (mul_done) state_next = FIX;
                FIX:     state_next = RESP;
                RESP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        prod_fix   = neg_reg ? (~prod_reg + 128'd1) : prod_reg;
        result_fix = prod_fix[127:64];
        case (op_reg)
            OP_MUL:  result_fix = prod_fix[63:0];
            OP_MULW: result_fix = {{32{prod_fix[31]}}, prod_fix[31:0]};
            default: result_fix = prod_fix[127:64];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_reg     <= OP_MUL;
            neg_reg    <= 1'b0;
            a_reg      <= 64'd0;
            b_reg      <= 64'd0;
            prod_reg   <= 128'd0;
            result_reg <= 64'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_reg  <= op_dec;
                neg_reg <= neg_dec;
                a_reg   <= mag_a;
                b_reg   <= mag_b;
            end
            if (state == WAIT && mul_done && !req.flush) prod_reg <= mul_c;
            if (state == FIX && !req.flush) result_reg <= result_fix;
        end
    end

    assign req.ready  = (state == IDLE);
    assign req.done   = (state == RESP) && !req.flush && !reset;
    assign req.result = result_reg;
    assign mul_valid  = (state == ISSUE) && !reset;
    assign mul_a      = a_reg;
    assign mul_b      = b_reg;
    assign fsm_state  = state;
endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit: a behavioural multiplier with programmable delay,
// a driver issuing requests, and a monitor scoring every done pulse against exp_q.
module tb_mul_unit;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic         clk;
  logic         reset;
  logic         mul_valid;
  logic [63:0]  mul_a, mul_b;
  logic         mul_done;
  logic [127:0] mul_c;
  logic [2:0]   fsm_state;

  mul_unit_if mif();

  mul_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req       (mif.slave),
    .mul_valid (mul_valid),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_c     (mul_c),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural unsigned multiplier; garbage on mul_c whenever not busy
  int           mul_delay;
  logic         m_busy;
  int           m_cnt;
  logic [63:0]  m_a, m_b;
  logic [127:0] m_prod;

  assign m_prod   = {64'd0, m_a} * {64'd0, m_b};
  assign mul_done = m_busy && (m_cnt >= mul_delay);
  assign mul_c    = m_busy ? m_prod : 128'hDEAD_BEEF_0BAD_F00D_DEAD_BEEF_0BAD_F00D;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_a    <= 64'd0;
      m_b    <= 64'd0;
    end else if (mul_valid) begin
      m_busy <= 1'b1;
      m_cnt  <= 0;
      m_a    <= mul_a;
      m_b    <= mul_b;
    end else if (m_busy) begin
      if (mul_done) m_busy <= 1'b0;
      else          m_cnt  <= m_cnt + 1;
    end
  end

  // scoreboard
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (reset === 1'b0 && mif.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with result 0x%0h, expected no done", mif.result);
      end else begin
        exp_v = exp_q.pop_front();
        check("result", {64'd0, mif.result}, {64'd0, exp_v});
      end
    end
  end

  // driver tasks
  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mif.ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=0 for 50 cycles, expected ready=1");
    end
  endtask

  task automatic drive_req(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
    mif.valid   = 1'b1;
    mif.funct3  = f3;
    mif.is_word = w;
    mif.srca    = a;
    mif.srcb    = b;
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                        input int delay, input int exp_lat);
    bit seen = 1'b0;
    int lat = 0;
    int nvalid = 0;
    int vcyc = 0;
    wait_ready();
    mul_delay = delay;
    drive_req(f3, w, a, b);
    exp_q.push_back(exp);
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) mif.valid = 1'b0;
      if (mul_valid === 1'b1) begin
        nvalid++;
        vcyc = c;
      end
      if (mif.done === 1'b1) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no done in 40 cycles, expected done at cycle %0d", name, exp_lat);
    end else begin
      check({name, "_latency"}, 128'(lat), 128'(exp_lat));
      check({name, "_mul_valid_count"}, 128'(nvalid), 128'd1);
      check({name, "_mul_valid_cycle"}, 128'(vcyc), 128'd1);
    end
  endtask

  task automatic abort_op(input string name, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] b, input int delay, input logic [2:0] target,
                          input logic use_reset);
    bit found = 1'b0;
    wait_ready();
    mul_delay = delay;
    drive_req(f3, 1'b0, a, b);
    @(negedge clk);
    mif.valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (fsm_state === target) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_reached_state"}, 128'(found), 128'd1);
    if (use_reset) reset = 1'b1;
    else           mif.flush = 1'b1;
    #1;
    check({name, "_done_suppressed"}, 128'(mif.done), 128'd0);
    @(negedge clk);
    reset     = 1'b0;
    mif.flush = 1'b0;
    check({name, "_ready_next"}, 128'(mif.ready), 128'd1);
    check({name, "_state_idle"}, 128'(fsm_state), 128'(S_IDLE));
    check({name, "_done_next"}, 128'(mif.done), 128'd0);
    if (use_reset) check({name, "_result_cleared"}, {64'd0, mif.result}, 128'd0);
  endtask

  task automatic idle_conflict(input string name, input logic use_reset);
    wait_ready();
    drive_req(3'b000, 1'b0, 64'd9, 64'd9);
    if (use_reset) reset = 1'b1;
    else           mif.flush = 1'b1;
    @(negedge clk);
    mif.valid = 1'b0;
    reset     = 1'b0;
    mif.flush = 1'b0;
    check({name, "_state_idle"}, 128'(fsm_state), 128'(S_IDLE));
    check({name, "_ready"}, 128'(mif.ready), 128'd1);
    check({name, "_mul_valid"}, 128'(mul_valid), 128'd0);
  endtask

  initial begin
    reset       = 1'b1;
    mif.valid   = 1'b0;
    mif.funct3  = 3'b000;
    mif.is_word = 1'b0;
    mif.srca    = 64'd0;
    mif.srcb    = 64'd0;
    mif.flush   = 1'b0;
    mul_delay   = 0;
    repeat (3) @(negedge clk);
    check("reset_done", 128'(mif.done), 128'd0);
    check("reset_mul_valid", 128'(mul_valid), 128'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_ready", 128'(mif.ready), 128'd1);
    check("reset_result", {64'd0, mif.result}, 128'd0);
    check("reset_state", 128'(fsm_state), 128'(S_IDLE));

    run_op("mul_3x5",      3'b000, 1'b0, 64'd3, 64'd5, 64'h0000_0000_0000_000F, 0, 4);
    run_op("mulh_min_sq",  3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000, 0, 4);
    run_op("mulh_m1_m1",   3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h0, 0, 4);
    run_op("mulhsu_ones",  3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 0, 4);
    run_op("mulhu_ones",   3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 0, 4);
    run_op("mulw_wrap",    3'b000, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFE, 0, 4);
    run_op("mulh_neg3x5",  3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
           64'hFFFF_FFFF_FFFF_FFFF, 0, 4);
    run_op("mul_neg3x5",   3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
           64'hFFFF_FFFF_FFFF_FFF1, 0, 4);
    run_op("mul_f3_110",   3'b110, 1'b0, 64'h0000_0001_0000_0001, 64'h10,
           64'h0000_0010_0000_0010, 0, 4);
    run_op("mulw_override", 3'b001, 1'b1, 64'hFFFF_FFFF_0000_0003, 64'h5,
           64'h0000_0000_0000_000F, 0, 4);

    abort_op("flush_wait", 3'b000, 64'd11, 64'd13, 10, S_WAIT, 1'b0);
    run_op("mul_7x6",      3'b000, 1'b0, 64'd7, 64'd6, 64'h2A, 0, 4);
    abort_op("flush_resp", 3'b011, 64'd4, 64'd4, 0, S_RESP, 1'b0);
    abort_op("reset_fix",  3'b000, 64'd21, 64'd2, 0, S_FIX, 1'b1);
    run_op("mulhu_stretch", 3'b011, 1'b0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000,
           64'h1, 3, 7);
    idle_conflict("flush_over_valid", 1'b0);
    idle_conflict("reset_over_valid", 1'b1);
    run_op("mul_after_conflict", 3'b000, 1'b0, 64'd100, 64'd100, 64'd10000, 0, 4);

    repeat (5) @(negedge clk);
    check("exp_q_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-003 SHALL have port valid, input, 1 bit: request strobe, sampled only when ready=1.
REQ-004 SHALL have port funct3, input, 3 bits: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx treated as MUL.
REQ-005 SHALL have port is_word, input, 1 bit: MULW request; overrides funct3.
REQ-006 SHALL have port srca, input, 64 bits (u64): rs1 operand.
REQ-007 SHALL have port srcb, input, 64 bits (u64): rs2 operand.
REQ-008 SHALL have port flush, input, 1 bit: abort any in-flight request.
REQ-009 SHALL have port ready, output, 1 bit: high only in state IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle result pulse.
REQ-011 SHALL have port result, output, 64 bits (u64): registered result, valid when done=1.
REQ-012 SHALL have port mul_valid, output, 1 bit: start strobe to the unsigned 64x64 multiplier.
REQ-013 SHALL have ports mul_a and mul_b, output, 64 bits each: unsigned multiplier operands, driven from registers.
REQ-014 SHALL have port mul_done, input, 1 bit: multiplier completion flag.
REQ-015 SHALL have port mul_c, input, 128 bits (u128): unsigned multiplier product.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, FIX and RESP.
REQ-017 SHALL, in IDLE with valid=1 and flush=0, latch op, magnitudes and neg flag, then go to ISSUE; valid SHALL otherwise be ignored.
REQ-018 SHALL compute magnitudes as follows: MULH uses |srca| and |srcb|; MULHSU uses |srca| and srcb; MULHU and MUL use raw operands; MULW uses zero-extended srca[31:0] and srcb[31:0].
REQ-019 SHALL map |0x8000_0000_0000_0000| to 0x8000_0000_0000_0000 (unsigned, no overflow).
REQ-020 SHALL set neg = sign(a) XOR sign(b) for MULH, neg = sign(a) for MULHSU, and neg = 0 otherwise.
REQ-021 SHALL assert mul_valid for exactly the one ISSUE cycle, with mul_a and mul_b stable from ISSUE through WAIT; ISSUE SHALL then go to WAIT unconditionally.
REQ-022 SHALL, in WAIT, capture mul_c into a 128-bit product register and go to FIX when mul_done=1, and otherwise stay in WAIT.
REQ-023 SHALL, in FIX, apply 128-bit two's-complement negation to the product if neg=1 and register the selected result, then go to RESP.
REQ-024 SHALL select the result as follows: MUL gives p[63:0]; MULH, MULHSU and MULHU give p[127:64]; MULW gives the sign-extension of p[31:0].
REQ-025 SHALL, in RESP, drive done=1 for one cycle and go to IDLE; result SHALL hold its value until the next FIX.
REQ-026 SHALL have a latency of 4 cycles from acceptance edge to done (accept at cycle 0, ISSUE 1, WAIT 2, FIX 3, RESP 4) when mul_done=1 on the first WAIT cycle.
REQ-027 SHALL, on flush=1 in any state, go to IDLE next cycle with no done pulse; flush SHALL take priority over valid in the same cycle, and RESP with flush SHALL suppress done.
REQ-028 SHALL accept a new request in the cycle immediately after RESP or after flush (back-to-back allowed).
REQ-029 SHALL ignore mul_c outside WAIT.

Reset
REQ-030 SHALL, on reset=1 in any state, go to IDLE next cycle; result, product and operand registers SHALL be cleared to 0.
REQ-031 SHALL drive done=0 and mul_valid=0 under reset; ready=1 from the first cycle after reset.
REQ-032 SHALL have reset override both flush and valid.

Verification
REQ-033 SHALL pass: MUL srca=3, srcb=5 -> done at cycle 4, result=0x0000_0000_0000_000F, mul_valid high exactly at cycle 1.
REQ-034 SHALL pass: MULH 0x8000_0000_0000_0000 x 0x8000_0000_0000_0000 -> 0x4000_0000_0000_0000; MULH -1 x -1 -> 0x0.
REQ-035 SHALL pass: MULHSU srca=0xFFFF_FFFF_FFFF_FFFF, srcb=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFF; MULHU with the same operands -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-036 SHALL pass: MULW srca=0x1234_5678_7FFF_FFFF, srcb=2 -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-037 SHALL pass: flush during WAIT -> no done pulse, ready=1 next cycle; a following MUL 7x6 -> 42 (0x2A) with 4-cycle latency.
REQ-038 SHALL pass: reset asserted in FIX -> done=0 and result=0 next cycle, then ready=1; holding mul_done=0 for 3 cycles in WAIT stretches latency to 7 cycles with the correct result.
